// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 640x480@60 Hz VGA scanout of an 80x60 RGB332 framebuffer.
// Each framebuffer pixel is replicated over an 8x8 block of screen pixels.
// Pixel rate is CLK/2; everything advances on the pix_en edges only.
// Pipeline: counters -> (RD_ADDR, act_d, hs_d, vs_d) -> (RGB, HS, VS).
// Optional build macro VGA_FB_BORDER_EN forces a white one-pixel border
// around the visible area, aligned with the RGB pipeline.
module vga_fb_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [12:0] RD_ADDR,
  input  logic [7:0]  RD_DATA,
  output logic [2:0]  ROUT,
  output logic [2:0]  GOUT,
  output logic [1:0]  BOUT,
  output logic        HS,
  output logic        VS,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       line_end;
  logic       frame_end;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic       act_d;
  logic       hs_d;
  logic       vs_d;
  logic [7:0] pix_word;

  // Timing decode of the current raster position.
  always_comb begin
    line_end  = (h_cnt == H_LAST);
    frame_end = (v_cnt == V_LAST);
    active    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

  // Divide CLK by two to produce the 25 MHz pixel strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  // Raster counters; end-of-line and end-of-frame wrap together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt <= 10'd0;
        v_cnt <= frame_end ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // One-CLK frame pulse on the pixel edge that wraps (last,last) to (0,0).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= pix_en && line_end && frame_end;
    end
  end

  // First stage: issue the framebuffer address and carry the timing
  // flags alongside it so they meet the returned data one pixel later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RD_ADDR <= 13'd0;
      act_d   <= 1'b0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
    end else if (pix_en) begin
      RD_ADDR <= {v_cnt[8:3], h_cnt[9:3]};
      act_d   <= active;
      hs_d    <= hs_raw;
      vs_d    <= vs_raw;
    end
  end

`ifdef VGA_FB_BORDER_EN
  localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

  logic border_raw;
  logic border_d;

  // Outermost visible rows/columns; blanking is applied later via act_d.
  always_comb begin
    border_raw = (h_cnt == 10'd0) || (h_cnt == H_VIS_LAST) ||
                 (v_cnt == 10'd0) || (v_cnt == V_VIS_LAST);
  end

  // Delay the border flag by the same stage as the address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      border_d <= 1'b0;
    end else if (pix_en) begin
      border_d <= border_raw;
    end
  end
`endif

  // Choose the pixel word: framebuffer data, border white, or blank.
  always_comb begin
    pix_word = RD_DATA;
`ifdef VGA_FB_BORDER_EN
    if (border_d) begin
      pix_word = 8'hFF;
    end
`endif
    if (!act_d) begin
      pix_word = 8'h00;
    end
  end

  // Second stage: drive the pins, RGB and syncs on the same pixel edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ROUT <= 3'd0;
      GOUT <= 3'd0;
      BOUT <= 2'd0;
      HS   <= 1'b1;
      VS   <= 1'b1;
    end else if (pix_en) begin
      ROUT <= pix_word[7:5];
      GOUT <= pix_word[4:2];
      BOUT <= pix_word[1:0];
      HS   <= hs_d;
      VS   <= vs_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: self-checking bench for vga_fb_scanout.
// A reduced-timing instance (80x22 raster) is checked every CLK against an
// arithmetic raster model; a default-timing instance checks real VGA
// line timing and the address map near the top of the frame.
// Honours VGA_FB_BORDER_EN the same way as the design.
module tb_vga_fb_scanout;

  // Reduced raster for the fully modelled instance.
  localparam int S_HV  = 64;
  localparam int S_HFP = 4;
  localparam int S_HS  = 8;
  localparam int S_HBP = 4;
  localparam int S_HT  = S_HV + S_HFP + S_HS + S_HBP;  // 80
  localparam int S_VV  = 16;
  localparam int S_VFP = 2;
  localparam int S_VS  = 2;
  localparam int S_VBP = 2;
  localparam int S_VT  = S_VV + S_VFP + S_VS + S_VBP;  // 22
  localparam int S_F   = S_HT * S_VT;                  // 1760 pixels/frame

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  // Reduced-timing DUT
  logic [12:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [2:0]  rout, gout;
  logic [1:0]  bout;
  logic        hs, vs, frame_start;

  vga_fb_scanout #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut (
    .CLK(clk), .RESET_N(reset_n), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .ROUT(rout), .GOUT(gout), .BOUT(bout), .HS(hs), .VS(vs),
    .FRAME_START(frame_start)
  );

  // Default-timing DUT
  logic [12:0] rd_addr_f;
  logic [7:0]  rd_data_f = 8'd0;
  logic [2:0]  rout_f, gout_f;
  logic [1:0]  bout_f;
  logic        hs_f, vs_f, fs_f;

  vga_fb_scanout dut_full (
    .CLK(clk), .RESET_N(reset_n), .RD_ADDR(rd_addr_f), .RD_DATA(rd_data_f),
    .ROUT(rout_f), .GOUT(gout_f), .BOUT(bout_f), .HS(hs_f), .VS(vs_f),
    .FRAME_START(fs_f)
  );

  // Synchronous-read framebuffer models
  logic [7:0] mem [0:8191];
  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) rd_data_f <= rd_addr_f[7:0];

  // Scoreboard state
  int errors = 0;
  int checks = 0;
  int n = 0;  // CLK rising edges since reset release

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
  endtask

  function automatic logic [12:0] addr_of(input int h, input int v);
    return 13'(((v / 8) % 64) * 128 + (h / 8) % 128);
  endfunction

  // Reference: outputs seen after CLK edge n. Pixel edges are the even
  // edges; edge 2k is the k-th pixel edge. The address reflects the raster
  // position one pixel edge back, the pins two pixel edges back.
  function automatic logic [23:0] model(input int cyc);
    int pe, p, h, v;
    logic [12:0] a;
    logic [7:0]  px;
    logic        hs_e, vs_e, fs_e;
    pe   = cyc / 2;
    a    = 13'd0;
    px   = 8'd0;
    hs_e = 1'b1;
    vs_e = 1'b1;
    fs_e = (cyc % 2 == 0) && (pe >= 1) && (pe % S_F == 0);
    if (pe >= 1) begin
      p = (pe - 1) % S_F;
      a = addr_of(p % S_HT, p / S_HT);
    end
    if (pe >= 2) begin
      p = (pe - 2) % S_F;
      h = p % S_HT;
      v = p / S_HT;
      hs_e = !(h >= S_HV + S_HFP && h < S_HV + S_HFP + S_HS);
      vs_e = !(v >= S_VV + S_VFP && v < S_VV + S_VFP + S_VS);
      if (h < S_HV && v < S_VV) begin
        px = mem[addr_of(h, v)];
`ifdef VGA_FB_BORDER_EN
        if (h == 0 || h == S_HV - 1 || v == 0 || v == S_VV - 1) px = 8'hFF;
`endif
      end
    end
    return {fs_e, hs_e, vs_e, px, a};
  endfunction

  function automatic logic [23:0] obs();
    return {frame_start, hs, vs, rout, gout, bout, rd_addr};
  endfunction

  task automatic test_reset();
    fill_random();
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== model(0)) begin
        errors++;
        $display("FAIL reset_state got=%h exp=%h", obs(), model(0));
      end
    end
    checks++;
    if ({rd_addr_f, hs_f, vs_f, rout_f, gout_f, bout_f, fs_f} !==
        {13'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_full got=%h exp=%h",
               {rd_addr_f, hs_f, vs_f, rout_f, gout_f, bout_f, fs_f},
               {13'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0});
    end
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL after_release n=%0d got=%h exp=%h", n, obs(), model(n));
      end
    end
  endtask

  task automatic test_full_timing();
    int first_fall, first_rise, second_fall;
    logic prev_hs, seen_vs_fs;
    first_fall = -1; first_rise = -1; second_fall = -1;
    prev_hs = 1'b1; seen_vs_fs = 1'b0;
    do_reset(10);
    for (int i = 0; i < 25625; i++) begin
      step();
      if (prev_hs && !hs_f) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
      end
      if (!prev_hs && hs_f && first_rise < 0) first_rise = n;
      prev_hs = hs_f;
      if (!vs_f || fs_f) seen_vs_fs = 1'b1;
      if (n == 25618) begin
        checks++;
        if (rd_addr_f !== 13'h101) begin
          errors++;
          $display("FAIL full_addr_8_16 got=%h exp=%h", rd_addr_f, 13'h101);
        end
      end
      if (n == 25620) begin
        checks++;
        if ({rout_f, gout_f, bout_f} !== 8'h01) begin
          errors++;
          $display("FAIL full_rgb_8_16 got=%h exp=%h", {rout_f, gout_f, bout_f}, 8'h01);
        end
      end
    end
    checks++;
    if (first_fall != 1316) begin
      errors++;
      $display("FAIL full_hs_first_fall got=%0d exp=%0d", first_fall, 1316);
    end
    checks++;
    if (first_rise - first_fall != 192) begin
      errors++;
      $display("FAIL full_hs_width got=%0d exp=%0d", first_rise - first_fall, 192);
    end
    checks++;
    if (second_fall - first_fall != 1600) begin
      errors++;
      $display("FAIL full_hs_period got=%0d exp=%0d", second_fall - first_fall, 1600);
    end
    checks++;
    if (seen_vs_fs !== 1'b0) begin
      errors++;
      $display("FAIL full_no_vs_fs got=%b exp=%b", seen_vs_fs, 1'b0);
    end
  endtask

  task automatic test_frame_timing();
    int fs_first, fs_last, fs_count, vs_low;
    fs_first = -1; fs_last = -1; fs_count = 0; vs_low = 0;
    fill_random();
    do_reset(6);
    for (int i = 0; i < 4 * S_F + 8; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL frame_timing n=%0d got=%h exp=%h", n, obs(), model(n));
      end
      if (frame_start) begin
        fs_count++;
        if (fs_first < 0) fs_first = n;
        fs_last = n;
      end
      if (!vs && n <= 3520) vs_low++;
    end
    checks++;
    if (fs_first != 3520) begin
      errors++;
      $display("FAIL fs_first got=%0d exp=%0d", fs_first, 3520);
    end
    checks++;
    if (fs_count != 2) begin
      errors++;
      $display("FAIL fs_count got=%0d exp=%0d", fs_count, 2);
    end
    checks++;
    if (fs_last - fs_first != 3520) begin
      errors++;
      $display("FAIL fs_period got=%0d exp=%0d", fs_last - fs_first, 3520);
    end
    checks++;
    if (vs_low != 320) begin
      errors++;
      $display("FAIL vs_low_clks got=%0d exp=%0d", vs_low, 320);
    end
  endtask

  task automatic test_address_map();
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i);
    do_reset(3);
    for (int i = 0; i < 2540; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL address_map n=%0d got=%h exp=%h", n, obs(), model(n));
      end
      if (n == 2528) begin
        checks++;
        if (rd_addr !== 13'h087) begin
          errors++;
          $display("FAIL addr_last_visible got=%h exp=%h", rd_addr, 13'h087);
        end
      end
      if (n == 2530) begin
        checks++;
        if ({rout, gout, bout} !== 8'h87) begin
          errors++;
          $display("FAIL rgb_last_visible got=%h exp=%h", {rout, gout, bout}, 8'h87);
        end
      end
    end
  endtask

  task automatic test_blanking();
    int white, other;
    white = 0; other = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'hFF;
    do_reset(5);
    for (int i = 0; i < 2 * S_F + 40; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL blanking n=%0d got=%h exp=%h", n, obs(), model(n));
      end
      if (n >= 4 && n <= 3523) begin
        if ({rout, gout, bout} == 8'hFF) white++;
        else if ({rout, gout, bout} != 8'h00) other++;
      end
    end
    checks++;
    if (white != 2048 || other != 0) begin
      errors++;
      $display("FAIL blanking_count got=%0d/%0d exp=%0d/%0d", white, other, 2048, 0);
    end
  endtask

  task automatic test_mid_frame_reset();
    int fs_first;
    fs_first = -1;
    fill_random();
    do_reset(4);
    for (int i = 0; i < 1661; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL pre_reset n=%0d got=%h exp=%h", n, obs(), model(n));
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== model(0)) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs(), model(0));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== model(0)) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=%h", obs(), model(0));
      end
    end
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * S_F + 10; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL post_reset n=%0d got=%h exp=%h", n, obs(), model(n));
      end
      if (frame_start && fs_first < 0) fs_first = n;
    end
    checks++;
    if (fs_first != 3520) begin
      errors++;
      $display("FAIL post_reset_fs got=%0d exp=%0d", fs_first, 3520);
    end
  endtask

  task automatic test_border();
    int white, expected;
`ifdef VGA_FB_BORDER_EN
    expected = 312;
`else
    expected = 0;
`endif
    white = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    do_reset(2);
    for (int i = 0; i < 2 * S_F + 40; i++) begin
      step();
      checks++;
      if (obs() !== model(n)) begin
        errors++;
        $display("FAIL border n=%0d got=%h exp=%h", n, obs(), model(n));
      end
      if (n >= 4 && n <= 3523 && {rout, gout, bout} == 8'hFF) white++;
    end
    checks++;
    if (white != expected) begin
      errors++;
      $display("FAIL border_count got=%0d exp=%0d", white, expected);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      do_reset($urandom_range(1, 5));
      len = $urandom_range(200, 1500);
      for (int i = 0; i < len; i++) begin
        step();
        checks++;
        if (obs() !== model(n)) begin
          errors++;
          $display("FAIL back_to_back k=%0d n=%0d got=%h exp=%h", k, n, obs(), model(n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_timing();
    test_frame_timing();
    test_address_map();
    test_blanking();
    test_mid_frame_reset();
    test_border();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
